ram_1_ctrl: RTL and testbench

//  Request/response front end sitting directly upstream of the 16x8 single-port RAM (ports clk, data, addr, we, re).

---
 rtl/ram_1_ctrl.sv | 121 ++++++++++++
 tb/tb_ram_1_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1_ctrl.sv
// Valid/ready command front end for a single-port RAM with a shared inout data bus.
// Optionally fills every word with FILL_VAL after reset before accepting commands.
//
// state    | meaning
// INIT     | one cycle after reset, chooses clear pass or idle
// CLEAR    | writes FILL_VAL to word cnt, one word per cycle
// IDLE     | ready for a command
// WR       | single write cycle, controller drives the bus
// RD_ISSUE | RAM registers the addressed word
// RD_CAP   | RAM drives the bus, data captured at the closing edge
module ram_1_ctrl #(
  parameter int              AW       = 4,
  parameter int              DW       = 8,
  parameter bit              CLEAR_EN = 1'b1,
  parameter logic [DW-1:0]   FILL_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  typedef enum logic [2:0] {INIT, CLEAR, IDLE, WR, RD_ISSUE, RD_CAP} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] wdata;

  // we and re are both registered, so the bus hand-over never overlaps
  assign mem_data = (mem_we && !mem_re) ? wdata : {DW{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      wdata     <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        INIT: begin
          if (CLEAR_EN) begin
            state    <= CLEAR;
            cnt      <= '0;
            mem_addr <= '0;
            wdata    <= FILL_VAL;
            mem_we   <= 1'b1;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        CLEAR: begin
          if (&cnt) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            wdata     <= req_wdata;
            if (req_wr) begin
              state  <= WR;
              mem_we <= 1'b1;
            end else begin
              state  <= RD_ISSUE;
              mem_re <= 1'b1;
            end
          end
        end
        WR: begin
          state     <= IDLE;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
        end
        RD_ISSUE: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          state     <= IDLE;
          mem_re    <= 1'b0;
          rsp_rdata <= mem_data;
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= INIT;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_1_ctrl.sv
// Bench for ram_1_ctrl: two instances (clear pass on / off), each with a behavioural 16x8 RAM.
// Expected read responses are queued at command accept and checked by a separate monitor thread.
module tb_ram_1_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   bus_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req_valid0 = 1'b0, req_wr0 = 1'b0;
  logic [3:0] req_addr0 = '0;
  logic [7:0] req_wdata0 = '0;
  logic       req_ready0, rsp_valid0, busy0, mem_we0, mem_re0;
  logic [7:0] rsp_rdata0;
  logic [3:0] mem_addr0;
  wire  [7:0] mem_data0;

  logic       req_valid1 = 1'b0, req_wr1 = 1'b0;
  logic [3:0] req_addr1 = '0;
  logic [7:0] req_wdata1 = '0;
  logic       req_ready1, rsp_valid1, busy1, mem_we1, mem_re1;
  logic [7:0] rsp_rdata1;
  logic [3:0] mem_addr1;
  wire  [7:0] mem_data1;

  ram_1_ctrl #(.AW(4), .DW(8), .CLEAR_EN(1'b1), .FILL_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_wr(req_wr0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .busy(busy0), .mem_we(mem_we0), .mem_re(mem_re0), .mem_addr(mem_addr0), .mem_data(mem_data0));

  ram_1_ctrl #(.AW(4), .DW(8), .CLEAR_EN(1'b0), .FILL_VAL(8'h00)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .busy(busy1), .mem_we(mem_we1), .mem_re(mem_re1), .mem_addr(mem_addr1), .mem_data(mem_data1));

  // RAM models: registered read output driven while re is high
  logic [7:0] ram0 [16];
  logic [7:0] ram1 [16];
  logic [7:0] out0 = 8'h00;
  logic [7:0] out1 = 8'h00;
  always @(posedge clk) begin
    if (mem_we0) ram0[mem_addr0] <= mem_data0;
    if (mem_re0) out0 <= ram0[mem_addr0];
    if (mem_we1) ram1[mem_addr1] <= mem_data1;
    if (mem_re1) out1 <= ram1[mem_addr1];
  end
  assign mem_data0 = mem_re0 ? out0 : 8'hzz;
  assign mem_data1 = mem_re1 ? out1 : 8'hzz;
  // probe pattern on the otherwise released bus; any controller drive corrupts it
  assign mem_data0 = (!mem_we0 && !mem_re0) ? 8'h5A : 8'hzz;

  typedef struct {logic [7:0] d; int due;} exp_t;
  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] model0 [16];
  logic [7:0] model1 [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid0) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          chk("rsp0_data", rsp_rdata0, e.d);
          chk("rsp0_cycle", cyc, e.due);
        end
      end
      if (rsp_valid1) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("rsp1_data", rsp_rdata1, e.d);
          chk("rsp1_cycle", cyc, e.due);
        end
      end
      if (bus_on) begin
        chk("bus_we_re_excl", mem_we0 & mem_re0, 0);
        if (mem_we0) chk("bus_wr_data", mem_data0, {4'h0, mem_addr0});
        else if (mem_re0) chk("bus_rd_known", $isunknown(mem_data0), 0);
        else chk("bus_released", mem_data0, 8'h5A);
      end
    end
  endtask

  // called at a negedge; returns at the negedge following the accept edge
  task automatic issue(input int dut, input logic wr, input logic [3:0] a, input logic [7:0] d,
                       input bit expect_rsp, output int acc);
    int   t;
    logic rdy;
    t = 0;
    acc = -1;
    if (dut == 0) begin req_valid0 = 1'b1; req_wr0 = wr; req_addr0 = a; req_wdata0 = d; end
    else begin req_valid1 = 1'b1; req_wr1 = wr; req_addr1 = a; req_wdata1 = d; end
    rdy = (dut == 0) ? req_ready0 : req_ready1;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
      rdy = (dut == 0) ? req_ready0 : req_ready1;
    end
    chk("req_accept", rdy, 1);
    if (rdy) begin
      acc = cyc + 1;
      if (dut == 0) begin
        if (wr) model0[a] = d;
        else if (expect_rsp) q0.push_back('{model0[a], acc + 2});
      end else begin
        if (wr) model1[a] = d;
        else if (expect_rsp) q1.push_back('{model1[a], acc + 2});
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drop_valid();
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // started just after the edge that releases reset
  task automatic after_reset();
    int   nb0, nb1, nw, rdy1_at;
    logic r0, r1;
    nb0 = 0; nb1 = 0; nw = 0; rdy1_at = -1; r0 = 1'b0; r1 = 1'b0;
    for (int k = 0; k < 40 && !(r0 && r1); k++) begin
      @(negedge clk);
      if (!r0) begin
        if (busy0) nb0++;
        if (mem_we0) begin
          chk("clear_addr", mem_addr0, nw[3:0]);
          chk("clear_data", mem_data0, 8'h00);
          nw++;
        end
        if (req_ready0) r0 = 1'b1;
      end
      if (!r1) begin
        if (busy1) nb1++;
        if (req_ready1) begin r1 = 1'b1; rdy1_at = k; end
      end
    end
    chk("clear_ready_seen", r0, 1);
    chk("clear_busy_cycles", nb0, 17);
    chk("clear_write_count", nw, 16);
    chk("clear_busy_after", busy0, 0);
    chk("noclr_busy_cycles", nb1, 1);
    chk("noclr_ready_cycle", rdy1_at, 1);
    for (int i = 0; i < 16; i++) model0[i] = 8'h00;
  endtask

  initial begin
    int acc, prev;
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready0, 0);
    chk("rst_busy", busy0, 1);
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_mem_re", mem_re0, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_rsp_rdata", rsp_rdata0, 0);
    chk("rst_bus_released", mem_data0, 8'h5A);
    @(posedge clk);
    #1 rst = 1'b0;

    // clear pass (dut0) and direct-to-idle (dut1)
    after_reset();

    // single write then read
    issue(0, 1'b1, 4'd3, 8'hA5, 1'b1, acc);
    issue(0, 1'b0, 4'd3, 8'h00, 1'b1, acc);
    drop_valid();
    wait_cycles(4);
    chk("t2_rsp_rdata_held", rsp_rdata0, 8'hA5);

    // back-to-back writes then reads with bus monitoring
    bus_on = 1'b1;
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b1, 4'(i), 8'(i), 1'b1, acc);
      if (i > 0) chk("wr_spacing", acc - prev, 2);
      prev = acc;
    end
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b0, 4'(i), 8'h00, 1'b1, acc);
      if (i > 0) chk("rd_spacing", acc - prev, 3);
      prev = acc;
    end
    drop_valid();
    wait_cycles(4);
    bus_on = 1'b0;
    chk("t3_queue_drained", q0.size(), 0);

    // reset during RD_CAP of addr 7
    issue(0, 1'b0, 4'd7, 8'h00, 1'b0, acc);
    drop_valid();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_mem_re_drop", mem_re0, 0);
    chk("t5_rsp_valid", rsp_valid0, 0);
    chk("t5_busy", busy0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    after_reset();
    issue(0, 1'b0, 4'd7, 8'h00, 1'b1, acc);
    drop_valid();
    wait_cycles(4);

    // instance without clear pass
    issue(1, 1'b1, 4'd15, 8'h3C, 1'b1, acc);
    issue(1, 1'b0, 4'd15, 8'h00, 1'b1, acc);
    drop_valid();
    wait_cycles(4);
    chk("t6_rsp_rdata", rsp_rdata1, 8'h3C);
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
